// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite types and constants for the SRAM responder and its decoder.
// Also holds the byte-lane merge helper used by the write port and read bypass.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strobe);
        logic [31:0] res;
        res = old_word;
        for (int l = 0; l < 4; l++) begin
            if (strobe[l]) begin
                res[8*l +: 8] = new_word[8*l +: 8];
            end else begin
                res[8*l +: 8] = old_word[8*l +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one manager and the SRAM responder.
// HREADY comes from the interconnect and is an input to both sides.
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_byte_lane_dec.sv
// Combinational HSIZE/HADDR[1:0] decode into little-endian byte strobes,
// flagging misaligned beats and sizes wider than a word.
module ahb_lite_byte_lane_dec
    import ahb_lite_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strobe,
    output logic       bad
);

    // Lane enables and alignment check for a single beat
    always_comb begin
        strobe = 4'b0000;
        bad    = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                strobe = 4'b0001 << addr_lo;
                bad    = 1'b0;
            end
            HSIZE_HALF: begin
                strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
                bad    = addr_lo[0];
            end
            HSIZE_WORD: begin
                strobe = 4'b1111;
                bad    = (addr_lo != 2'b00);
            end
            default: begin
                strobe = 4'b0000;
                bad    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory behind the address/data
// pipeline, with programmable wait states and the two-cycle ERROR response.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_lite_sram_slave_if.slave  bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    slv_state_e     state_r, state_nxt_s;
    logic [3:0]     cnt_r, cnt_nxt_s;
    logic [AW-1:0]  idx_r, idx_s, rd_idx_s;
    logic           write_r, rd_s, take_s, commit_s;
    logic [3:0]     strobe_r, strobe_s;
    logic           size_bad_s, err_s, accept_s;
    logic [32:0]    diff_s;
    logic           hreadyout_r, hresp_r;
    logic [31:0]    hrdata_r, hrdata_nxt_s, rd_word_s;
    logic [31:0]    mem_r [DEPTH];
    logic           unused_s;

    ahb_lite_byte_lane_dec u_dec (
        .hsize   (bus.HSIZE),
        .addr_lo (bus.HADDR[1:0]),
        .strobe  (strobe_s),
        .bad     (size_bad_s)
    );

    // Borrow out of the subtraction flags addresses below the window
    assign diff_s   = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
    assign idx_s    = diff_s[AW+1:2];
    assign err_s    = size_bad_s | diff_s[32] | ({1'b0, diff_s[31:0]} >= SPAN);
    assign accept_s = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign commit_s = (state_r == ST_DATA) & write_r;
    assign rd_idx_s = take_s ? idx_s : idx_r;
    assign rd_s     = take_s ? ~bus.HWRITE : ~write_r;
    assign unused_s = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

    // Next-state decode; DATA and ERR2 accept back-to-back exactly like IDLE
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        take_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    take_s = 1'b1;
                    if (err_s) begin
                        state_nxt_s = ST_ERR1;
                    end else if (WAIT_STATES != 32'd0) begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = 4'(WAIT_STATES - 32'd1);
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read word for the coming data phase, forwarding a write committing on the same edge
    always_comb begin
        rd_word_s = mem_r[rd_idx_s];
        if (commit_s && (idx_r == rd_idx_s)) begin
            rd_word_s = merge_lanes(mem_r[rd_idx_s], bus.HWDATA, strobe_r);
        end else begin
            rd_word_s = mem_r[rd_idx_s];
        end
        if (((state_nxt_s == ST_WAIT) || (state_nxt_s == ST_DATA)) && rd_s) begin
            hrdata_nxt_s = rd_word_s;
        end else begin
            hrdata_nxt_s = 32'd0;
        end
    end

    // SRAM write port: commits only at the edge ending a write DATA cycle
    always_ff @(posedge HCLK) begin
        if (HRESET && commit_s) begin
            mem_r[idx_r] <= merge_lanes(mem_r[idx_r], bus.HWDATA, strobe_r);
        end
    end

    // State, captured transfer attributes and registered bus outputs
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            idx_r       <= {AW{1'b0}};
            write_r     <= 1'b0;
            strobe_r    <= 4'b0000;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            hrdata_r    <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (take_s) begin
                idx_r    <= idx_s;
                write_r  <= bus.HWRITE & ~err_s;
                strobe_r <= strobe_s;
            end
            hreadyout_r <= (state_nxt_s != ST_WAIT) && (state_nxt_s != ST_ERR1);
            hresp_r     <= ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) ?
                           HRESP_ERROR : HRESP_OKAY;
            hrdata_r    <= hrdata_nxt_s;
        end
    end

    assign bus.HREADYOUT = hreadyout_r;
    assign bus.HRESP     = hresp_r;
    assign bus.HRDATA    = hrdata_r;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: two responders (0 and 3 wait states) driven from a
// vector table through a pipelined manager with an expected-result queue.
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    localparam int unsigned DEPTH = 1024;

    typedef struct {
        logic [2:0] size;
        logic [1:0] lo;
        logic [3:0] strobe;
        logic       bad;
    } dec_vec_t;

    typedef struct {
        int          ws;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } bus_vec_t;

    typedef struct {
        int          tag;
        logic        wr;
        logic        err;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    logic        hsel, hwrite, hready_low;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    int          cur;

    logic [2:0] dec_size;
    logic [1:0] dec_lo;
    logic [3:0] dec_strobe;
    logic       dec_bad;

    int total = 0;
    int bad   = 0;

    dec_vec_t dvec[$];
    bus_vec_t vec[$];
    exp_t     exp_q[$];

    ahb_lite_sram_slave_if b0 ();
    ahb_lite_sram_slave_if b3 ();

    assign b0.HSEL   = hsel && (cur == 0);
    assign b3.HSEL   = hsel && (cur == 3);
    assign b0.HADDR  = haddr;   assign b3.HADDR  = haddr;
    assign b0.HTRANS = htrans;  assign b3.HTRANS = htrans;
    assign b0.HWRITE = hwrite;  assign b3.HWRITE = hwrite;
    assign b0.HSIZE  = hsize;   assign b3.HSIZE  = hsize;
    assign b0.HBURST = 3'd0;    assign b3.HBURST = 3'd0;
    assign b0.HPROT  = 4'd3;    assign b3.HPROT  = 4'd3;
    assign b0.HWDATA = hwdata;  assign b3.HWDATA = hwdata;
    assign b0.HREADY = hready_low ? 1'b0 : b0.HREADYOUT;
    assign b3.HREADY = hready_low ? 1'b0 : b3.HREADYOUT;

    ahb_lite_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(b0.slave));
    ahb_lite_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(b3.slave));

    ahb_lite_byte_lane_dec u_dec (
        .hsize(dec_size), .addr_lo(dec_lo), .strobe(dec_strobe), .bad(dec_bad));

    function automatic logic rdy();
        return (cur == 3) ? b3.HREADYOUT : b0.HREADYOUT;
    endfunction
    function automatic logic resp();
        return (cur == 3) ? b3.HRESP : b0.HRESP;
    endfunction
    function automatic logic [31:0] rdata();
        return (cur == 3) ? b3.HRDATA : b0.HRDATA;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic addv(input int ws, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic err, input logic [31:0] rd);
        bus_vec_t v;
        v.ws = ws; v.wr = wr; v.size = size; v.addr = addr;
        v.wdata = wd; v.err = err; v.rdata = rd;
        vec.push_back(v);
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2; haddr = 32'd0;
    endtask

    // Pipelined manager: plays vec[first..last] back-to-back on DUT 'cur'
    task automatic run_bus(input int first, input int last);
        int   nxt = first;
        int   budget = 0;
        int   waits = 0;
        logic acc_pend = 1'b0;
        logic dp_v = 1'b0;
        exp_t e;
        while ((nxt <= last || acc_pend || dp_v) && budget < 200) begin
            @(negedge HCLK);
            budget++;
            if (acc_pend) begin
                dp_v = 1'b1; acc_pend = 1'b0; waits = 0;
            end
            hwdata = (dp_v && exp_q[0].wr) ? exp_q[0].wdata : 32'd0;
            if (dp_v) begin
                if (!rdy()) begin
                    waits++;
                    check($sformatf("v%0d wait_resp", exp_q[0].tag), 32'(resp()), 32'(exp_q[0].err));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d resp", e.tag), 32'(resp()), 32'(e.err));
                    check($sformatf("v%0d rdata", e.tag), rdata(),
                          (e.wr || e.err) ? 32'd0 : e.rdata);
                    check($sformatf("v%0d waits", e.tag), 32'(waits), 32'(e.waits));
                    dp_v = 1'b0;
                end
            end
            if (rdy()) begin
                if (nxt <= last) begin
                    hsel = 1'b1; htrans = 2'd2; hwrite = vec[nxt].wr;
                    hsize = vec[nxt].size; haddr = vec[nxt].addr;
                    e.tag = nxt; e.wr = vec[nxt].wr; e.err = vec[nxt].err;
                    e.wdata = vec[nxt].wdata; e.rdata = vec[nxt].rdata;
                    e.waits = vec[nxt].err ? 1 : vec[nxt].ws;
                    exp_q.push_back(e);
                    acc_pend = 1'b1;
                    nxt++;
                end else begin
                    drive_idle();
                end
            end
        end
        if (budget >= 200) begin
            total++; bad++;
            $display("FAIL timeout: vectors %0d..%0d stuck at %0d", first, last, nxt);
            exp_q.delete();
            drive_idle();
        end
    endtask

    initial begin
        HRESET = 1'b0; hready_low = 1'b0; cur = 0; hwdata = 32'd0;
        drive_idle();

        // Decoder table: {size, addr[1:0], strobe, bad}
        dvec.push_back('{3'd0, 2'd0, 4'b0001, 1'b0});
        dvec.push_back('{3'd0, 2'd3, 4'b1000, 1'b0});
        dvec.push_back('{3'd1, 2'd0, 4'b0011, 1'b0});
        dvec.push_back('{3'd1, 2'd2, 4'b1100, 1'b0});
        dvec.push_back('{3'd1, 2'd1, 4'b0000, 1'b1});
        dvec.push_back('{3'd2, 2'd0, 4'b1111, 1'b0});
        dvec.push_back('{3'd2, 2'd2, 4'b0000, 1'b1});
        dvec.push_back('{3'd3, 2'd0, 4'b0000, 1'b1});
        dvec.push_back('{3'd7, 2'd0, 4'b0000, 1'b1});

        // Bus table: ws, wr, size, addr, wdata, err, expected rdata
        addv(0, 1'b1, 3'd2, 32'h10,   32'hDEAD_BEEF, 1'b0, 32'h0);           // 0
        addv(0, 1'b0, 3'd2, 32'h10,   32'h0,         1'b0, 32'hDEAD_BEEF);   // 1
        addv(0, 1'b1, 3'd0, 32'h20,   32'h0000_0011, 1'b0, 32'h0);           // 2
        addv(0, 1'b1, 3'd0, 32'h21,   32'h0000_2200, 1'b0, 32'h0);           // 3
        addv(0, 1'b1, 3'd0, 32'h22,   32'h0033_0000, 1'b0, 32'h0);           // 4
        addv(0, 1'b1, 3'd0, 32'h23,   32'h4400_0000, 1'b0, 32'h0);           // 5
        addv(0, 1'b0, 3'd2, 32'h20,   32'h0,         1'b0, 32'h4433_2211);   // 6
        addv(0, 1'b1, 3'd1, 32'h22,   32'hABCD_0000, 1'b0, 32'h0);           // 7
        addv(0, 1'b0, 3'd2, 32'h20,   32'h0,         1'b0, 32'hABCD_2211);   // 8
        addv(0, 1'b1, 3'd2, 32'h0,    32'h0BAD_F00D, 1'b0, 32'h0);           // 9
        addv(0, 1'b1, 3'd2, 32'h2,    32'hFFFF_FFFF, 1'b1, 32'h0);           // 10
        addv(0, 1'b1, 3'd3, 32'h0,    32'hFFFF_FFFF, 1'b1, 32'h0);           // 11
        addv(0, 1'b1, 3'd2, 32'h1000, 32'hFFFF_FFFF, 1'b1, 32'h0);           // 12
        addv(0, 1'b0, 3'd2, 32'h0,    32'h0,         1'b0, 32'h0BAD_F00D);   // 13
        addv(0, 1'b0, 3'd1, 32'h1,    32'h0,         1'b1, 32'h0);           // 14
        addv(0, 1'b0, 3'd0, 32'h23,   32'h0,         1'b0, 32'hABCD_2211);   // 15
        addv(0, 1'b1, 3'd1, 32'h20,   32'h0000_5566, 1'b0, 32'h0);           // 16
        addv(0, 1'b0, 3'd2, 32'h20,   32'h0,         1'b0, 32'hABCD_5566);   // 17
        addv(0, 1'b1, 3'd2, 32'hFFC,  32'h7777_0001, 1'b0, 32'h0);           // 18
        addv(0, 1'b0, 3'd2, 32'hFFC,  32'h0,         1'b0, 32'h7777_0001);   // 19
        addv(0, 1'b0, 3'd2, 32'h10,   32'h0,         1'b0, 32'hDEAD_BEEF);   // 20
        addv(3, 1'b1, 3'd2, 32'h0,    32'h1234_5678, 1'b0, 32'h0);           // 21
        addv(3, 1'b1, 3'd2, 32'h40,   32'hCAFE_F00D, 1'b0, 32'h0);           // 22
        addv(3, 1'b0, 3'd2, 32'h0,    32'h0,         1'b0, 32'h1234_5678);   // 23
        addv(3, 1'b0, 3'd2, 32'h40,   32'h0,         1'b0, 32'hCAFE_F00D);   // 24
        addv(3, 1'b1, 3'd2, 32'h6,    32'hFFFF_FFFF, 1'b1, 32'h0);           // 25
        addv(3, 1'b0, 3'd2, 32'h40,   32'h0,         1'b0, 32'hCAFE_F00D);   // 26

        for (int i = 0; i < dvec.size(); i++) begin
            dec_size = dvec[i].size; dec_lo = dvec[i].lo;
            #1;
            check($sformatf("dec%0d bad", i), 32'(dec_bad), 32'(dvec[i].bad));
            if (!dvec[i].bad) check($sformatf("dec%0d strobe", i), 32'(dec_strobe), 32'(dvec[i].strobe));
        end

        repeat (3) @(negedge HCLK);
        check("rst hreadyout0", 32'(b0.HREADYOUT), 32'd1);
        check("rst hresp0", 32'(b0.HRESP), 32'd0);
        check("rst hrdata0", b0.HRDATA, 32'd0);
        check("rst hreadyout3", 32'(b3.HREADYOUT), 32'd1);
        HRESET = 1'b1;

        cur = 0;
        run_bus(0, 19);

        // Another slave stalls the bus: NONSEQ write must not be taken
        @(negedge HCLK);
        hready_low = 1'b1; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1;
        hsize = 3'd2; haddr = 32'h10; hwdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check($sformatf("stall%0d hreadyout", i), 32'(b0.HREADYOUT), 32'd1);
            check($sformatf("stall%0d hresp", i), 32'(b0.HRESP), 32'd0);
        end
        hready_low = 1'b0; drive_idle(); hwdata = 32'd0;

        // BUSY while selected: zero-wait OKAY, no data
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'd1; hwrite = 1'b0; haddr = 32'h10;
        @(negedge HCLK);
        check("busy hreadyout", 32'(b0.HREADYOUT), 32'd1);
        check("busy hresp", 32'(b0.HRESP), 32'd0);
        check("busy hrdata", b0.HRDATA, 32'd0);
        drive_idle();
        run_bus(20, 20);

        cur = 3;
        run_bus(21, 25);

        // Reset during the second wait cycle of a write to 0x40
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
        @(negedge HCLK);
        check("abort w1 hreadyout", 32'(b3.HREADYOUT), 32'd0);
        drive_idle(); hwdata = 32'h1111_1111;
        @(negedge HCLK);
        check("abort w2 hreadyout", 32'(b3.HREADYOUT), 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        HRESET = 1'b1; hwdata = 32'd0;
        check("abort hreadyout", 32'(b3.HREADYOUT), 32'd1);
        check("abort hresp", 32'(b3.HRESP), 32'd0);
        run_bus(26, 26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite subordinate (responder) end of the `wrap` bus: a single-port word-organised SRAM reached through the standard address-phase/data-phase pipeline.
- Drives HREADYOUT, HRESP, HRDATA in answer to manager-driven HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA.
- Provides programmable wait states and the two-cycle ERROR response.
- Serves as the DUT-side responder that the interface wrapper and testbench monitor observe.

Parameters:
- DEPTH, 1024, number of 32-bit words; word index is HADDR[$clog2(DEPTH)+1:2].
- BASE_ADDR, 32'h0000_0000, first byte address decoded as in-range.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (legal 0..15).

Ports:
- HCLK  input  1  bus clock; all state updates on the rising edge.
- HRESET  input  1  synchronous, active-low reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  32  byte address (address phase).
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  0=byte, 1=half, 2=word; larger values are illegal.
- HBURST  input  3  accepted, ignored (each beat decoded independently).
- HPROT  input  4  accepted, ignored.
- HWDATA  input  32  write data (data phase).
- HREADY  input  1  bus-wide ready; an address phase is valid only when HREADY=1.
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0=OKAY, 1=ERROR.
- HRDATA  output  32  read data.

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESET is synchronous and active-low. While HRESET=0 at a rising edge: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0. SRAM contents are not cleared.
- Accept rule: a transfer is accepted at an edge where HSEL=1, HREADY=1 and HTRANS[1]=1.
  - On acceptance, register addr_q, write_q, size_q and strobe_q.
  - HTRANS IDLE/BUSY while selected gives a zero-wait OKAY data phase with no side effect.
- Error conditions, evaluated in the address phase:
  - word index >= DEPTH, or HADDR < BASE_ADDR;
  - HSIZE > 2;
  - misaligned: HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accept with error -> ERR1. Accept with OKAY and WAIT_STATES>0 -> WAIT (counter=WAIT_STATES-1). Accept with OKAY and WAIT_STATES=0 -> DATA.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; -> DATA when counter=0.
  - DATA: HREADYOUT=1, HRESP=0. This is the final data-phase cycle. A new accept in this cycle follows the IDLE transitions (back-to-back); otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; -> ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept follows the IDLE transitions; otherwise -> IDLE.
- Writes: HWDATA is sampled only at the edge ending the DATA cycle. Only lanes in strobe_q are written.
  - Byte: lane = addr_q[1:0].
  - Half: lanes {addr_q[1]*2, +1}.
  - Word: all four lanes.
  - Little-endian lane mapping. ERROR transfers never write.
- Reads: during WAIT/DATA of a read, HRDATA = mem[addr_q] as a full word (manager extracts lanes). HRDATA=0 in IDLE, ERR1, ERR2 and during write data phases.
- Write-then-read same address, back-to-back: the write commits on the same edge that starts the read data phase, so the read returns the new data.
- Addresses are never incremented internally, so there is no wrap-around logic.
- HREADY=0 during IDLE (another slave stalling): no acceptance; outputs stay at IDLE values.
- Reset asserted mid-WAIT or mid-ERR1: the pending transfer is abandoned with no memory write, and the next cycle shows IDLE outputs.

Decomposition:
- Package ahb_lite_pkg holds:
  - enums htrans_e and hsize_e;
  - HRESP_OKAY and HRESP_ERROR constants;
  - slave state enum {IDLE, WAIT, DATA, ERR1, ERR2}.
- Sub-module ahb_lite_byte_lane_dec: combinational; HSIZE + HADDR[1:0] -> 4-bit strobe plus misalign/illegal-size flag. Reused by the bench scoreboard.

Test Plan:
- WAIT_STATES=0. Word write 32'hDEAD_BEEF @0x10, then read @0x10 back-to-back -> HREADYOUT stays 1, HRESP=0, HRDATA=32'hDEAD_BEEF in the read data phase.
- Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, then word read @0x20 -> HRDATA=32'h4433_2211. Half write 16'hABCD @0x22 then word read -> 32'hABCD_2211.
- WAIT_STATES=3. Read @0x0 -> exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with valid data; a NONSEQ presented in that cycle is accepted.
- Error cases: word access @0x2 (misaligned), HSIZE=3, and address DEPTH*4 -> each gives cycle1 {HREADYOUT=0,HRESP=1}, cycle2 {1,1}; memory unchanged on readback.
- HREADY=0 with HSEL=1, HTRANS=NONSEQ for 4 cycles -> no acceptance, no write; HTRANS=BUSY -> zero-wait OKAY, HRDATA=0.
- WAIT_STATES=3. HRESET=0 during the second wait cycle of a write to 0x40 -> next cycle HREADYOUT=1, HRESP=0; read @0x40 returns the prior contents.
